layer0_window_feeder: RTL and testbench

//  Streaming sliding-window generator directly upstream of layer 0. Takes a

---
 rtl/layer0_window_feeder.sv | 89 ++++++++
 tb/tb_layer0_window_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/layer0_window_feeder.sv
// layer0_window_feeder: raster pixel stream to stride-1 KSIZE x KSIZE sliding windows for layer 0.
module layer0_window_feeder #(
  parameter int BIT_DATA = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int KSIZE    = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BIT_DATA-1:0]             in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [KSIZE*KSIZE*BIT_DATA-1:0] out_window,
  output logic                            frame_done
);
  localparam int W  = KSIZE*KSIZE*BIT_DATA;
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                out_valid_q, last_q;
  logic [W-1:0]        out_window_q, win_pack;
  logic                acc, col_end, row_end, emit;
  logic [BIT_DATA-1:0] lb_q  [KSIZE-1][IMG_W];
  logic [BIT_DATA-1:0] win_q [KSIZE][KSIZE];
  logic [BIT_DATA-1:0] win_d [KSIZE][KSIZE];
  assign in_ready   = !out_valid_q | out_ready;
  assign acc        = in_valid & in_ready;
  assign col_end    = col_q == CW'(IMG_W-1);
  assign row_end    = row_q == RW'(IMG_H-1);
  assign emit       = acc & (state_q == RUN) & (row_q >= RW'(KSIZE-1)) & (col_q >= CW'(KSIZE-1));
  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign frame_done = out_valid_q & out_ready & last_q;
  // Rightmost column comes from the line buffers (oldest row on top) plus the incoming pixel.
  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
      if (c < KSIZE-1) begin : g_shift
        assign win_d[r][c] = win_q[r][c+1];
      end else if (r < KSIZE-1) begin : g_lb
        assign win_d[r][c] = lb_q[r][col_q];
      end else begin : g_in
        assign win_d[r][c] = in_data;
      end
      assign win_pack[BIT_DATA*(r*KSIZE+c) +: BIT_DATA] = win_d[r][c];
    end
  end
  always_comb begin
    col_d   = acc ? (col_end ? '0 : col_q + CW'(1)) : col_q;
    row_d   = (acc & col_end) ? (row_end ? '0 : row_q + RW'(1)) : row_q;
    state_d = !(acc & col_end) ? state_q :
              (row_q == RW'(KSIZE-2)) ? RUN :
              row_end ? FILL : state_q;
  end
  // Line buffers and window taps are fully rewritten during FILL and priming, so no reset.
  always_ff @(posedge clock) begin
    if (acc) begin
      for (int r = 0; r < KSIZE-1; r++) lb_q[r][col_q] <= win_d[r+1][KSIZE-1];
      win_q <= win_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (emit) begin
        out_valid_q  <= 1'b1;
        out_window_q <= win_pack;
        last_q       <= col_end & row_end;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        last_q      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_layer0_window_feeder.sv
// tb_layer0_window_feeder: directed checks of windowing, backpressure, gaps, frame boundaries and reset.
module tb_layer0_window_feeder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [71:0] out_window;
  logic        frame_done;
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int first_cyc = -1;
  int wins = 0;
  int fd_cnt = 0;
  logic hold_v = 1'b0;
  logic [71:0] hold_w = '0;
  logic [71:0] exp_w[$];
  logic        exp_l[$];
  logic [71:0] got[$];
  logic acc;

  layer0_window_feeder #(.BIT_DATA(8), .IMG_W(5), .IMG_H(5), .KSIZE(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] mkwin(input int base, input bit neg, input int r, input int c);
    logic [71:0] w;
    int v;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        v = base + (r-2+i)*5 + (c-2+j);
        if (neg) v = -v;
        w[8*(i*3+j) +: 8] = v[7:0];
      end
    return w;
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, output logic a);
    logic [71:0] ew;
    logic el;
    @(negedge clock);
    in_valid = v; in_data = d; out_ready = rdy;
    #1;
    cyc_n++;
    if (hold_v) begin
      chk("hold_valid", 72'(out_valid), 72'(1));
      chk("hold_window", out_window, hold_w);
    end
    if (out_valid && !rdy) chk("in_ready_stall", 72'(in_ready), 72'(0));
    else chk("in_ready", 72'(in_ready), 72'(1));
    if (out_valid && first_cyc < 0) first_cyc = cyc_n;
    if (out_valid && rdy) begin
      chk("window_avail", 72'(exp_w.size() > 0), 72'(1));
      if (exp_w.size() > 0) begin
        ew = exp_w.pop_front();
        el = exp_l.pop_front();
        chk("window", out_window, ew);
        chk("frame_done", 72'(frame_done), 72'(el));
      end
      got.push_back(out_window);
      wins++;
      if (frame_done) fd_cnt++;
    end else chk("frame_done_idle", 72'(frame_done), 72'(0));
    hold_v = out_valid && !rdy;
    hold_w = out_window;
    a = v && in_ready;
  endtask

  task automatic send_frame(input int base, input bit neg, input bit gap, input int stall_idx, input int last_idx);
    int v, tries;
    logic a;
    for (int idx = 0; idx <= last_idx; idx++) begin
      v = neg ? -idx : base + idx;
      if (idx == stall_idx) repeat (4) begin
        cyc(1'b1, v[7:0], 1'b0, a);
        chk("stall_no_accept", 72'(a), 72'(0));
      end
      tries = 0;
      do begin
        cyc(1'b1, v[7:0], 1'b1, a);
        tries++;
      end while (!a && tries < 20);
      chk("pixel_accepted", 72'(a), 72'(1));
      if (idx/5 >= 2 && idx%5 >= 2) begin
        exp_w.push_back(mkwin(base, neg, idx/5, idx%5));
        exp_l.push_back(idx == 24);
      end
      if (gap) cyc(1'b0, 8'h00, 1'b1, a);
    end
  endtask

  task automatic drain();
    logic a;
    int n;
    n = 0;
    while (exp_w.size() > 0 && n < 20) begin
      cyc(1'b0, 8'h00, 1'b1, a);
      n++;
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b1, a);
    chk("drain_empty", 72'(exp_w.size()), 72'(0));
  endtask

  task automatic clear_stats();
    wins = 0; fd_cnt = 0; first_cyc = -1;
    got.delete();
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_out_valid", 72'(out_valid), 72'(0));
    chk("reset_out_window", out_window, 72'(0));
    chk("reset_frame_done", 72'(frame_done), 72'(0));
    reset = 1'b0;

    // 1: continuous stream
    clear_stats();
    t0 = cyc_n;
    send_frame(0, 1'b0, 1'b0, -1, 24);
    drain();
    chk("t1_count", 72'(wins), 72'(9));
    chk("t1_frame_done_cnt", 72'(fd_cnt), 72'(1));
    chk("t1_latency", 72'(first_cyc), 72'(t0 + 14));
    chk("t1_first", got[0], {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
    chk("t1_last", got[8], {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12});

    // 2: consumer stall while window 13 is pending
    clear_stats();
    send_frame(0, 1'b0, 1'b0, 14, 24);
    drain();
    chk("t2_count", 72'(wins), 72'(9));
    chk("t2_second", got[1], {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1});

    // 3: in_valid toggling
    clear_stats();
    send_frame(0, 1'b0, 1'b1, -1, 24);
    drain();
    chk("t3_count", 72'(wins), 72'(9));
    chk("t3_last", got[8], {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12});

    // 4: two frames back to back
    clear_stats();
    send_frame(0, 1'b0, 1'b0, -1, 24);
    send_frame(100, 1'b0, 1'b0, -1, 24);
    drain();
    chk("t4_count", 72'(wins), 72'(18));
    chk("t4_frame_done_cnt", 72'(fd_cnt), 72'(2));
    chk("t4_f2_first", got[9], {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100});

    // 5: reset after pixel 17 with its window still pending
    clear_stats();
    send_frame(0, 1'b0, 1'b0, -1, 17);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_valid_after_reset", 72'(out_valid), 72'(0));
    chk("t5_window_after_reset", out_window, 72'(0));
    exp_w.delete();
    exp_l.delete();
    hold_v = 1'b0;
    clear_stats();
    send_frame(0, 1'b0, 1'b0, -1, 24);
    drain();
    chk("t5_count", 72'(wins), 72'(9));
    chk("t5_first", got[0], {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});

    // 6: negative pixels
    clear_stats();
    send_frame(0, 1'b1, 1'b0, -1, 24);
    drain();
    chk("t6_count", 72'(wins), 72'(9));
    chk("t6_tap8", 72'(got[0][71:64]), 72'(8'hF4));
    chk("t6_tap0", 72'(got[0][7:0]), 72'(8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
